flow_ctrl_unit: RTL and testbench

Parametrised program-flow unit and successor to the single-condition zero-flag jump. It owns the registered program counter. It resolves unconditional and flag-conditional jumps (Z, NZ, C, N), and implements CALL/RET through an internal return-address stack. It sits between the decode stage (op, target address from GPR) and instruction fetch (pc). It raises a sticky fault on stack overflow or underflow.

---
 rtl/flow_ctrl_unit.sv | 142 ++++++++++++++
 tb/tb_flow_ctrl_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/flow_ctrl_unit.sv
// rtl/flow_ctrl_unit.sv - program counter with conditional jumps and CALL/RET return-address stack
// Faults on stack overflow/underflow and freezes until clear_fault.
module flow_ctrl_unit #(
  parameter int          ADDR_W       = 20,
  parameter int          STACK_DEPTH  = 8,
  parameter int          PC_STEP      = 1,
  parameter int unsigned RESET_VECTOR = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             en,
  input  logic [2:0]                       op,
  input  logic                             zero_flag,
  input  logic                             carry_flag,
  input  logic                             neg_flag,
  input  logic [ADDR_W-1:0]                jmp_address,
  input  logic                             clear_fault,
  output logic [ADDR_W-1:0]                pc,
  output logic                             taken,
  output logic [$clog2(STACK_DEPTH+1)-1:0] sp,
  output logic                             fault,
  output logic [1:0]                       fault_code
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = $clog2(STACK_DEPTH);

  localparam logic [2:0] OP_SEQ   = 3'd0;
  localparam logic [2:0] OP_JMP   = 3'd1;
  localparam logic [2:0] OP_JMPZ  = 3'd2;
  localparam logic [2:0] OP_JMPNZ = 3'd3;
  localparam logic [2:0] OP_JMPC  = 3'd4;
  localparam logic [2:0] OP_JMPN  = 3'd5;
  localparam logic [2:0] OP_CALL  = 3'd6;
  localparam logic [2:0] OP_RET   = 3'd7;

  typedef enum logic {ST_RUN, ST_FAULT} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [SP_W-1:0]     sp_q, sp_d;
  logic                taken_q, taken_d;
  logic [1:0]          code_q, code_d;
  logic [ADDR_W-1:0]   stack_q [STACK_DEPTH];
  logic                push;
  logic [ADDR_W-1:0]   seq_pc;
  logic [SP_W-1:0]     sp_dec;

  assign seq_pc = pc_q + ADDR_W'(PC_STEP);
  assign sp_dec = sp_q - SP_W'(1);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    taken_d = 1'b0;
    code_d  = code_q;
    push    = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (en) begin
          case (op)
            OP_SEQ: pc_d = seq_pc;
            OP_JMP: begin
              pc_d    = jmp_address;
              taken_d = 1'b1;
            end
            OP_JMPZ, OP_JMPNZ, OP_JMPC, OP_JMPN: begin
              if ((op == OP_JMPZ  &&  zero_flag) ||
                  (op == OP_JMPNZ && !zero_flag) ||
                  (op == OP_JMPC  &&  carry_flag) ||
                  (op == OP_JMPN  &&  neg_flag)) begin
                pc_d    = jmp_address;
                taken_d = 1'b1;
              end else begin
                pc_d = seq_pc;
              end
            end
            OP_CALL: begin
              if (sp_q == SP_W'(STACK_DEPTH)) begin
                code_d  = 2'b01;
                state_d = ST_FAULT;
              end else begin
                push    = 1'b1;
                sp_d    = sp_q + SP_W'(1);
                pc_d    = jmp_address;
                taken_d = 1'b1;
              end
            end
            default: begin
              if (sp_q == '0) begin
                code_d  = 2'b10;
                state_d = ST_FAULT;
              end else begin
                sp_d    = sp_dec;
                pc_d    = stack_q[sp_dec[IDX_W-1:0]];
                taken_d = 1'b1;
              end
            end
          endcase
        end
      end
      default: begin
        // pc, sp and the stack stay frozen; only clear_fault is honoured
        if (clear_fault) begin
          state_d = ST_RUN;
          code_d  = 2'b00;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pc_q    <= ADDR_W'(RESET_VECTOR);
      sp_q    <= '0;
      taken_q <= 1'b0;
      code_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      taken_q <= taken_d;
      code_q  <= code_d;
    end
  end

  // Stack contents are don't-care after reset, so no reset here
  always_ff @(posedge clk) begin
    if (push) begin
      stack_q[sp_q[IDX_W-1:0]] <= seq_pc;
    end
  end

  assign pc         = pc_q;
  assign taken      = taken_q;
  assign sp         = sp_q;
  assign fault      = (state_q == ST_FAULT);
  assign fault_code = code_q;

endmodule

// File: tb/tb_flow_ctrl_unit.sv
// tb/tb_flow_ctrl_unit.sv - self-checking bench for flow_ctrl_unit
// Directed scenarios followed by randomized ops against a queue-based model.
module tb_flow_ctrl_unit;

  localparam int       DEPTH = 8;
  localparam longint   MASK  = 64'hFFFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [2:0]  op = 3'd0;
  logic        zero_flag = 1'b0, carry_flag = 1'b0, neg_flag = 1'b0;
  logic [19:0] jmp_address = '0;
  logic        clear_fault = 1'b0;
  logic [19:0] pc;
  logic        taken;
  logic [3:0]  sp;
  logic        fault;
  logic [1:0]  fault_code;

  flow_ctrl_unit dut (
    .clk(clk), .rst_n(rst_n), .en(en), .op(op),
    .zero_flag(zero_flag), .carry_flag(carry_flag), .neg_flag(neg_flag),
    .jmp_address(jmp_address), .clear_fault(clear_fault),
    .pc(pc), .taken(taken), .sp(sp), .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  longint m_pc;
  longint m_stack[$];
  bit     m_taken, m_fault;
  int     m_code;
  int     n_checks = 0;
  int     n_errors = 0;
  string  phase = "reset";

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s/%s: got %0h expected %0h", phase, tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("pc", 64'(pc), 64'(m_pc));
    chk("taken", 64'(taken), 64'(m_taken));
    chk("sp", 64'(sp), 64'(m_stack.size()));
    chk("fault", 64'(fault), 64'(m_fault));
    chk("fault_code", 64'(fault_code), 64'(m_code));
  endtask

  task automatic model_reset();
    m_pc = 0;
    m_stack.delete();
    m_taken = 0;
    m_fault = 0;
    m_code = 0;
  endtask

  task automatic model_step();
    longint seq;
    bit     cond;
    seq = (m_pc + 1) & MASK;
    m_taken = 0;
    if (m_fault) begin
      if (clear_fault) begin
        m_fault = 0;
        m_code = 0;
      end
    end else if (en) begin
      case (op)
        3'd0: m_pc = seq;
        3'd1: begin m_pc = jmp_address; m_taken = 1; end
        3'd2, 3'd3, 3'd4, 3'd5: begin
          cond = (op == 3'd2) ? zero_flag : (op == 3'd3) ? !zero_flag :
                 (op == 3'd4) ? carry_flag : neg_flag;
          if (cond) begin m_pc = jmp_address; m_taken = 1; end
          else m_pc = seq;
        end
        3'd6: begin
          if (m_stack.size() == DEPTH) begin m_fault = 1; m_code = 1; end
          else begin m_stack.push_back(seq); m_pc = jmp_address; m_taken = 1; end
        end
        default: begin
          if (m_stack.size() == 0) begin m_fault = 1; m_code = 2; end
          else begin m_pc = m_stack.pop_back(); m_taken = 1; end
        end
      endcase
    end
  endtask

  task automatic drive(input logic [2:0] o, input logic [19:0] a, input bit z = 0,
                       input bit c = 0, input bit n = 0, input bit e = 1, input bit clr = 0);
    op = o; jmp_address = a; zero_flag = z; carry_flag = c; neg_flag = n;
    en = e; clear_fault = clr;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  // Called #1 after a posedge: asserts reset asynchronously, releases before the next edge
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_pc", 64'(pc), 64'h0);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #12;
    check_all();
    rst_n = 1'b1;

    phase = "reset";
    drive(3'd1, 20'h00123);
    chk("jmp_pc", 64'(pc), 64'h123);
    async_reset();
    for (int i = 1; i <= 4; i++) begin
      drive(3'd0, 20'h0);
      chk("seq_pc", 64'(pc), 64'(i));
    end

    phase = "cond";
    for (int k = 0; k < 4; k++) begin
      drive(3'd1, 20'h00010);
      drive(3'(2 + k), 20'h00400, (k == 1), 1'b0, 1'b0);
      chk("false_pc", 64'(pc), 64'h11);
      drive(3'd1, 20'h00010);
      drive(3'(2 + k), 20'h00400, (k == 0), (k == 2), (k == 3));
      chk("true_pc", 64'(pc), 64'h400);
      chk("true_taken", 64'(taken), 64'h1);
      drive(3'd0, 20'h0);
    end

    phase = "nest";
    drive(3'd1, 20'h00100);
    drive(3'd6, 20'h00200);
    chk("call1_pc", 64'(pc), 64'h200);
    drive(3'd6, 20'h00300);
    chk("call2_sp", 64'(sp), 64'h2);
    drive(3'd7, 20'h0ABCD);
    chk("ret1_pc", 64'(pc), 64'h201);
    drive(3'd7, 20'h0);
    chk("ret2_pc", 64'(pc), 64'h101);
    chk("ret2_sp", 64'(sp), 64'h0);

    phase = "overflow";
    for (int i = 0; i < DEPTH; i++) drive(3'd6, 20'(32'h1000 + i));
    drive(3'd6, 20'h02000);
    chk("ovf_pc", 64'(pc), 64'h1007);
    chk("ovf_sp", 64'(sp), 64'h8);
    chk("ovf_code", 64'(fault_code), 64'h1);
    drive(3'd0, 20'h0);
    drive(3'd1, 20'h0);
    drive(3'd0, 20'h0, 0, 0, 0, 1, 1);
    chk("clr_fault", 64'(fault), 64'h0);
    drive(3'd0, 20'h0);
    chk("resume_pc", 64'(pc), 64'h1008);
    for (int i = 0; i < DEPTH; i++) drive(3'd7, 20'h0);

    phase = "underflow";
    drive(3'd7, 20'h0);
    chk("udf_code", 64'(fault_code), 64'h2);
    drive(3'd0, 20'h0);
    async_reset();

    phase = "wrap";
    drive(3'd1, 20'hFFFFF);
    drive(3'd0, 20'h0);
    chk("wrap_pc", 64'(pc), 64'h0);
    for (int i = 0; i < 3; i++) drive(3'd1, 20'h00555, 0, 0, 0, 0);
    chk("gated_pc", 64'(pc), 64'h0);

    phase = "random";
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) async_reset();
      drive(3'($urandom_range(0, 7)), 20'($urandom),
            bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
            ($urandom_range(0, 4) != 0), ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
